// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//            Shift-add multiply and restoring divide, one bit per cycle,
//            followed by a single sign-fixup cycle.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] win,
   input  logic             hi_wen,
   input  logic             lo_wen,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             neg_q;       // product / quotient must be negated
   logic             neg_r;       // remainder must be negated
   logic             div_zero;
   logic [WIDTH-1:0] opa_orig;    // raw dividend, returned in HI on divide-by-zero
   logic [WIDTH-1:0] mag_op;      // multiplicand (mult) or divisor (div) magnitude
   logic [WIDTH-1:0] acc;         // product upper half / partial remainder
   logic [WIDTH-1:0] lsr;         // multiplier bits / dividend->quotient bits

   // Operand magnitudes and signs at launch
   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & opa[WIDTH-1];
   assign b_neg     = signed_op & opb[WIDTH-1];
   assign abs_a     = a_neg ? (~opa + 1'b1) : opa;
   assign abs_b     = b_neg ? (~opb + 1'b1) : opb;

   // One shift-add step: the carry out of the add lands in the top bit
   // of the right-shifted product.
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   msum;

   assign addend = lsr[0] ? mag_op : '0;
   assign msum   = {1'b0, acc} + {1'b0, addend};

   // One restoring-divide step. The shifted remainder is always below twice
   // the divisor, so bit WIDTH of the difference is a reliable borrow flag.
   logic [WIDTH:0] dshift;
   logic [WIDTH:0] ddiff;

   assign dshift = {acc, lsr[WIDTH-1]};
   assign ddiff  = dshift - {1'b0, mag_op};

   // Sign fixup of the finished magnitudes
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;

   assign prod   = {acc, lsr};
   assign prod_s = neg_q ? (~prod + 1'b1) : prod;
   assign quo_s  = neg_q ? (~lsr + 1'b1) : lsr;
   assign rem_s  = neg_r ? (~acc + 1'b1) : acc;

   // Control FSM, datapath iteration and HI/LO/busy/done registers
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         opa_orig <= '0;
         mag_op   <= '0;
         acc      <= '0;
         lsr      <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (hi_wen) hi <= win;
               if (lo_wen) lo <= win;
               if (start) begin
                  state    <= S_CALC;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  is_div   <= op[1];
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= op[1] & (opb == '0);
                  opa_orig <= opa;
                  mag_op   <= op[1] ? abs_b : abs_a;
                  lsr      <= op[1] ? abs_a : abs_b;
                  acc      <= '0;
               end
            end
            S_CALC: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  if (!ddiff[WIDTH]) begin
                     acc <= ddiff[WIDTH-1:0];
                     lsr <= {lsr[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= dshift[WIDTH-1:0];
                     lsr <= {lsr[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= msum[WIDTH:1];
                  lsr <= {msum[0], lsr[WIDTH-1:1]};
               end
               if (cnt == LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (!is_div) begin
                  hi <= prod_s[2*WIDTH-1:WIDTH];
                  lo <= prod_s[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= opa_orig;
                  lo <= '1;
               end else begin
                  hi <= rem_s;
                  lo <= quo_s;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit. Expected HI/LO pairs are
//            computed from reference arithmetic when an operation is launched
//            and compared when the unit pulses done.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

   logic        clk;
   logic        clrn;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        start;
   logic [1:0]  op;
   logic [31:0] win;
   logic        hi_wen;
   logic        lo_wen;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int          n_cmp;
   int          n_err;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .clrn   (clrn),
      .opa    (opa),
      .opb    (opb),
      .start  (start),
      .op     (op),
      .win    (win),
      .hi_wen (hi_wen),
      .lo_wen (lo_wen),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference result {hi, lo} from plain 64-bit arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint r64;
      longint q64;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      res = '0;
      case (o)
         OP_MULT:  begin r64 = sa * sb; res = r64; end
         OP_MULTU: res = ua * ub;
         OP_DIV: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else begin
               q64 = sa / sb;
               r64 = sa % sb;
               res = {r64[31:0], q64[31:0]};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return res;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding launch
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check("result_hi", {32'h0, hi}, {32'h0, e[63:32]});
            check("result_lo", {32'h0, lo}, {32'h0, e[31:0]});
            m_hi = e[63:32];
            m_lo = e[31:0];
         end
      end
   end

   // Present an operation on one edge; optionally with an mthi write alongside
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit with_hw, input logic [31:0] wv);
      @(posedge clk);
      #1;
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = b;
      if (with_hw) begin
         hi_wen = 1'b1;
         win    = wv;
      end
      if (push) sb_q.push_back(model(o, a, b));
      @(posedge clk);
      #1;
      start  = 1'b0;
      hi_wen = 1'b0;
      opa    = $urandom;
      opb    = $urandom;
      op     = 2'($urandom_range(0, 3));
   endtask

   // Wait for done with a cycle budget; reports latency and busy-cycle count
   task automatic wait_done(output int lat, output int bcnt);
      bit got;
      got  = 1'b0;
      lat  = 0;
      bcnt = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
         if (done) got = 1'b1;
      end
      if (!got) check("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int lat;
      int bcnt;
      n_cmp  = 0;
      n_err  = 0;
      m_hi   = '0;
      m_lo   = '0;
      clrn   = 1'b0;
      start  = 1'b0;
      op     = '0;
      opa    = '0;
      opb    = '0;
      win    = '0;
      hi_wen = 1'b0;
      lo_wen = 1'b0;
      repeat (3) @(posedge clk);
      #1 clrn = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_hi",   {32'h0, hi},   64'd0);
      check("rst_lo",   {32'h0, lo},   64'd0);
      check("rst_busy", {63'h0, busy}, 64'd0);
      check("rst_done", {63'h0, done}, 64'd0);

      // multu max*max: latency and busy window
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
      check("busy_after_e0", {63'h0, busy}, 64'd1);
      wait_done(lat, bcnt);
      check("latency", lat, 64'd34);
      check("busy_cycles", bcnt, 64'd33);
      @(negedge clk);
      check("done_one_cycle", {63'h0, done}, 64'd0);

      // Signed multiply and divide with negative operands
      launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);
      launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);

      // Divide by zero (unsigned and signed) and the signed overflow case
      launch(OP_DIVU, 32'd100, 32'd0, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);
      check("divz_latency", lat, 64'd34);
      launch(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);

      // A few more patterns, including back-to-back start on the done cycle
      launch(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);
      #1;
      start = 1'b1; op = OP_MULT; opa = 32'h8000_0000; opb = 32'h8000_0000;
      sb_q.push_back(model(OP_MULT, 32'h8000_0000, 32'h8000_0000));
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_accepted", {63'h0, busy}, 64'd1);
      wait_done(lat, bcnt);
      check("b2b_latency", lat, 64'd34);
      for (int k = 0; k < 4; k++) begin
         logic [1:0]  ro;
         logic [31:0] ra;
         logic [31:0] rb;
         ro = 2'(k);
         ra = $urandom;
         rb = (k >= 2) ? 32'($urandom_range(1, 1000)) : $urandom;
         launch(ro, ra, rb, 1'b1, 1'b0, 32'h0);
         wait_done(lat, bcnt);
      end

      // Second start while busy is ignored; operand changes have no effect
      launch(OP_DIVU, 32'd10, 32'd3, 1'b1, 1'b0, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = OP_MULTU; opa = 32'd2; opb = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0; opa = 32'hDEAD_BEEF; opb = 32'd5;
      wait_done(lat, bcnt);
      repeat (40) @(negedge clk);
      check("ignored_start_idle", {63'h0, busy}, 64'd0);

      // mthi while idle updates on the next edge
      @(posedge clk);
      #1 hi_wen = 1'b1; win = 32'h1234_5678;
      @(posedge clk);
      #1 hi_wen = 1'b0;
      m_hi = 32'h1234_5678;
      check("mthi_idle", {32'h0, hi}, {32'h0, m_hi});

      // mtlo while busy is dropped
      launch(OP_MULT, 32'd5, 32'd6, 1'b1, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1 lo_wen = 1'b1; win = 32'hAAAA_5555;
      @(posedge clk);
      #1 lo_wen = 1'b0;
      check("mtlo_busy_ignored", {32'h0, lo}, {32'h0, m_lo});
      wait_done(lat, bcnt);

      // mthi alongside start: lands at E0, then overwritten by the result
      launch(OP_MULTU, 32'd1000, 32'd3000, 1'b1, 1'b1, 32'h55AA_55AA);
      check("mthi_with_start", {32'h0, hi}, 64'h55AA_55AA);
      wait_done(lat, bcnt);

      // Asynchronous reset in the middle of a multiply
      launch(OP_MULT, 32'hFFFF_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0);
      repeat (10) @(posedge clk);
      #3 clrn = 1'b0;
      #1;
      check("abort_hi",   {32'h0, hi},   64'd0);
      check("abort_lo",   {32'h0, lo},   64'd0);
      check("abort_busy", {63'h0, busy}, 64'd0);
      check("abort_done", {63'h0, done}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_busy", {63'h0, busy}, 64'd0);
      launch(OP_MULT, 32'hFFFF_1234, 32'h0000_4321, 1'b1, 1'b0, 32'h0);
      wait_done(lat, bcnt);
      check("post_reset_latency", lat, 64'd34);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
